typing_game_sequencer: RTL and testbench

- Top-level game controller for the four-letter typing game.
- Draws words from a 32-entry word ROM using a pseudo-random address, and presents currentWord/nextWord to the per-keystroke word checker.
- Consumes the checker's wordComplete/gameOver results, runs a per-word countdown timer, keeps score and sequences start, play and game-over.

---
 rtl/typing_game_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_typing_game_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/typing_game_sequencer.sv
// typing_game_sequencer: game controller for the four-letter typing game.
// Draws words from a 32-entry ROM via a 5-bit LFSR address, feeds the word
// checker, runs the per-word countdown and keeps the score.
// Optional feature macro: SPEEDUP_EN. When it is defined, the per-word time
// allowance shrinks by one tick after every fourth completed word.
// ROM reads take one clk, so the address of the word after nextWord is always
// issued ahead of time. That word is then already on romData when a word
// completes, and ADVANCE can capture it in a single clk.
module typing_game_sequencer #(
  parameter int         WORD_W     = 20,
  parameter int         TICK_DIV   = 100000000,
  parameter int         TIME_LIMIT = 10,
  parameter int         SCORE_W    = 8,
  parameter logic [4:0] LFSR_SEED  = 5'b00001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               wordComplete,
  input  logic               mistake,
  output logic [4:0]         romAddr,
  input  logic [WORD_W-1:0]  romData,
  output logic [WORD_W-1:0]  currentWord,
  output logic [WORD_W-1:0]  nextWord,
  output logic               checkerReset,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         timeLeft,
  output logic               playing,
  output logic               gameOver
);

  localparam int         PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0] LIMIT    = 8'(TIME_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH1  = 3'd1,
    S_FETCH2  = 3'd2,
    S_FETCH3  = 3'd3,
    S_PLAY    = 3'd4,
    S_ADVANCE = 3'd5,
    S_OVER    = 3'd6
  } state_t;

  // Fibonacci LFSR for x^5+x^3+1, shifting right; visits 1..31 only.
  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    return {v[0] ^ v[2], v[4:1]};
  endfunction

  state_t              state_q, state_d;
  logic [4:0]          lfsr_q, lfsr_d;
  logic [4:0]          rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0]   cur_word_q, cur_word_d;
  logic [WORD_W-1:0]   next_word_q, next_word_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [7:0]          time_q, time_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                chk_rst_q, chk_rst_d;
  logic                playing_q, playing_d;
  logic                game_over_q, game_over_d;
  // bit 2 = start, bit 1 = wordComplete, bit 0 = mistake
  logic [2:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]          prev_q, prev_d, pulse_q, pulse_d;
  logic                start_p, done_p, miss_p, tick_s;
  logic [7:0]          reload_s;

`ifdef SPEEDUP_EN
  logic [7:0]          reload_q, reload_d;
  assign reload_s = reload_q;
`else
  assign reload_s = LIMIT;
`endif

  assign start_p = pulse_q[2];
  assign done_p  = pulse_q[1];
  assign miss_p  = pulse_q[0];
  assign tick_s  = (pre_q == PRE_TERM);

  // Two-flop synchronisers followed by registered rising-edge detectors.
  always_comb begin
    sync1_d = {start, wordComplete, mistake};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  // Game sequencing: next state, word/score/timer updates, registered outputs.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    rom_addr_d  = rom_addr_q;
    cur_word_d  = cur_word_q;
    next_word_d = next_word_q;
    score_d     = score_q;
    time_d      = time_q;
    pre_d       = pre_q;
    chk_rst_d   = 1'b0;
`ifdef SPEEDUP_EN
    reload_d    = reload_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_p) begin
          score_d    = {SCORE_W{1'b0}};
          rom_addr_d = lfsr_q;
          lfsr_d     = lfsr_next(lfsr_q);
          state_d    = S_FETCH1;
`ifdef SPEEDUP_EN
          reload_d   = LIMIT;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH1: begin
        rom_addr_d = lfsr_q;
        lfsr_d     = lfsr_next(lfsr_q);
        state_d    = S_FETCH2;
      end
      S_FETCH2: begin
        cur_word_d = romData;
        state_d    = S_FETCH3;
      end
      S_FETCH3: begin
        next_word_d = romData;
        time_d      = reload_s;
        pre_d       = {PRE_W{1'b0}};
        chk_rst_d   = 1'b1;
        rom_addr_d  = lfsr_q;
        lfsr_d      = lfsr_next(lfsr_q);
        state_d     = S_PLAY;
      end
      S_PLAY: begin
        if (tick_s) begin
          pre_d = {PRE_W{1'b0}};
          if (time_q != 8'd0) begin
            time_d = time_q - 8'd1;
          end else begin
            time_d = time_q;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        if (miss_p) begin
          state_d = S_OVER;
        end else if (done_p) begin
          cur_word_d = next_word_q;
          if (score_q == {SCORE_W{1'b1}}) begin
            score_d = score_q;
          end else begin
            score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
          end
          rom_addr_d = lfsr_q;
          lfsr_d     = lfsr_next(lfsr_q);
          state_d    = S_ADVANCE;
`ifdef SPEEDUP_EN
          if ((score_q[1:0] == 2'b11) && (reload_q > 8'd1)) begin
            reload_d = reload_q - 8'd1;
          end else begin
            reload_d = reload_q;
          end
`endif
        end else if (tick_s && (time_q == 8'd1)) begin
          time_d  = 8'd0;
          state_d = S_OVER;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_ADVANCE: begin
        next_word_d = romData;
        time_d      = reload_s;
        pre_d       = {PRE_W{1'b0}};
        chk_rst_d   = 1'b1;
        state_d     = S_PLAY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    playing_d   = (state_d == S_PLAY) || (state_d == S_ADVANCE);
    game_over_d = (state_d == S_OVER);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      rom_addr_q  <= 5'd0;
      cur_word_q  <= {WORD_W{1'b0}};
      next_word_q <= {WORD_W{1'b0}};
      score_q     <= {SCORE_W{1'b0}};
      time_q      <= 8'd0;
      pre_q       <= {PRE_W{1'b0}};
      chk_rst_q   <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      prev_q      <= 3'b000;
      pulse_q     <= 3'b000;
`ifdef SPEEDUP_EN
      reload_q    <= LIMIT;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      rom_addr_q  <= rom_addr_d;
      cur_word_q  <= cur_word_d;
      next_word_q <= next_word_d;
      score_q     <= score_d;
      time_q      <= time_d;
      pre_q       <= pre_d;
      chk_rst_q   <= chk_rst_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      pulse_q     <= pulse_d;
`ifdef SPEEDUP_EN
      reload_q    <= reload_d;
`endif
    end
  end

  assign romAddr      = rom_addr_q;
  assign currentWord  = cur_word_q;
  assign nextWord     = next_word_q;
  assign checkerReset = chk_rst_q;
  assign score        = score_q;
  assign timeLeft     = time_q;
  assign playing      = playing_q;
  assign gameOver     = game_over_q;

endmodule

// File: tb/tb_typing_game_sequencer.sv
// Directed testbench for typing_game_sequencer (TICK_DIV=4, TIME_LIMIT=3,
// SCORE_W=2). Inputs change and outputs are sampled on the falling edge.
module tb_typing_game_sequencer;
  localparam int WORD_W = 20;
  localparam int SCORE_W = 2;
`ifdef SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, wordComplete, mistake;
  logic [4:0] romAddr;
  logic [WORD_W-1:0] romData = '0;
  logic [WORD_W-1:0] currentWord, nextWord;
  logic checkerReset, playing, gameOver;
  logic [SCORE_W-1:0] score;
  logic [7:0] timeLeft;
  int checks = 0;
  int errors = 0;

  typing_game_sequencer #(.WORD_W(WORD_W), .TICK_DIV(4), .TIME_LIMIT(3), .SCORE_W(SCORE_W), .LFSR_SEED(5'b00001)) dut (
    .clk(clk), .reset(reset), .start(start), .wordComplete(wordComplete), .mistake(mistake),
    .romAddr(romAddr), .romData(romData), .currentWord(currentWord), .nextWord(nextWord),
    .checkerReset(checkerReset), .score(score), .timeLeft(timeLeft), .playing(playing), .gameOver(gameOver));

  always #5 clk = ~clk;

  // ROM contents: two fixed entries from the test plan, the rest tagged by address.
  function automatic logic [WORD_W-1:0] rom_word(input logic [4:0] a);
    if (a == 5'd1) return 20'h0A4C2;
    else if (a == 5'd16) return 20'h12345;
    else return {15'h1234, a};
  endfunction

  // Synchronous ROM model: one clk of read latency.
  always @(posedge clk) romData <= rom_word(romAddr);

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; wordComplete = 1'b0; mistake = 1'b0;
    cyc(3);
    checks++; if (romAddr !== 5'd0) begin errors++; $display("FAIL rst_romAddr: got %0d want 0", romAddr); end
    checks++; if (currentWord !== 20'h0 || nextWord !== 20'h0) begin errors++; $display("FAIL rst_words: got %h %h want 0 0", currentWord, nextWord); end
    checks++; if (score !== 2'd0 || timeLeft !== 8'd0) begin errors++; $display("FAIL rst_score_time: got %0d %0d want 0 0", score, timeLeft); end
    checks++; if (playing !== 1'b0 || gameOver !== 1'b0 || checkerReset !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b%b want 000", playing, gameOver, checkerReset); end
    reset = 1'b0;
    cyc(2);
    checks++; if (playing !== 1'b0 || romAddr !== 5'd0) begin errors++; $display("FAIL idle_hold: got %b %0d want 0 0", playing, romAddr); end
  endtask

  task automatic test_start;
    start = 1'b1; cyc(2); start = 1'b0; cyc(2);
    checks++; if (romAddr !== 5'd1 || playing !== 1'b0) begin errors++; $display("FAIL start_addr1: got %0d %b want 1 0", romAddr, playing); end
    cyc(1);
    checks++; if (romAddr !== 5'd16) begin errors++; $display("FAIL start_addr16: got %0d want 16", romAddr); end
    cyc(2);
    checks++; if (currentWord !== 20'h0A4C2) begin errors++; $display("FAIL start_cur: got %h want 0a4c2", currentWord); end
    checks++; if (nextWord !== 20'h12345) begin errors++; $display("FAIL start_next: got %h want 12345", nextWord); end
    checks++; if (checkerReset !== 1'b1 || playing !== 1'b1) begin errors++; $display("FAIL start_flags: got %b %b want 1 1", checkerReset, playing); end
    checks++; if (timeLeft !== 8'd3 || romAddr !== 5'd8) begin errors++; $display("FAIL start_time_prefetch: got %0d %0d want 3 8", timeLeft, romAddr); end
    cyc(1);
    checks++; if (checkerReset !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL start_pulse_end: got %b %b want 0 1", checkerReset, playing); end
  endtask

  task automatic test_advance;
    wordComplete = 1'b1; cyc(2); wordComplete = 1'b0; cyc(2);
    checks++; if (currentWord !== 20'h12345 || score !== 2'd1) begin errors++; $display("FAIL adv_cur_score: got %h %0d want 12345 1", currentWord, score); end
    checks++; if (romAddr !== 5'd4 || playing !== 1'b1 || checkerReset !== 1'b0) begin errors++; $display("FAIL adv_addr: got %0d %b %b want 4 1 0", romAddr, playing, checkerReset); end
    cyc(1);
    checks++; if (nextWord !== rom_word(5'd8)) begin errors++; $display("FAIL adv_next: got %h want %h", nextWord, rom_word(5'd8)); end
    checks++; if (timeLeft !== 8'd3 || checkerReset !== 1'b1) begin errors++; $display("FAIL adv_reload: got %0d %b want 3 1", timeLeft, checkerReset); end
  endtask

  task automatic test_timeout;
    logic [7:0] exp_t;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      exp_t = (i < 4) ? 8'd3 : (i < 8) ? 8'd2 : (i < 12) ? 8'd1 : 8'd0;
      checks++; if (timeLeft !== exp_t || gameOver !== (i == 12)) begin errors++; $display("FAIL timeout_step%0d: got %0d %b want %0d %b", i, timeLeft, gameOver, exp_t, (i == 12)); end
    end
    checks++; if (playing !== 1'b0 || score !== 2'd1 || currentWord !== 20'h12345) begin errors++; $display("FAIL timeout_hold: got %b %0d %h want 0 1 12345", playing, score, currentWord); end
  endtask

  task automatic test_simultaneous;
    start = 1'b1; cyc(2); start = 1'b0; cyc(2);
    checks++; if (romAddr !== 5'd18 || score !== 2'd0 || gameOver !== 1'b0) begin errors++; $display("FAIL restart1: got %0d %0d %b want 18 0 0", romAddr, score, gameOver); end
    cyc(3);
    checks++; if (currentWord !== rom_word(5'd18) || nextWord !== rom_word(5'd9) || playing !== 1'b1) begin errors++; $display("FAIL restart1_words: got %h %h %b want %h %h 1", currentWord, nextWord, playing, rom_word(5'd18), rom_word(5'd9)); end
    wordComplete = 1'b1; mistake = 1'b1; cyc(2); wordComplete = 1'b0; mistake = 1'b0; cyc(2);
    checks++; if (gameOver !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL both_over: got %b %b want 1 0", gameOver, playing); end
    checks++; if (score !== 2'd0 || currentWord !== rom_word(5'd18)) begin errors++; $display("FAIL both_score: got %0d %h want 0 %h", score, currentWord, rom_word(5'd18)); end
  endtask

  task automatic test_restart;
    start = 1'b1; cyc(2); start = 1'b0; cyc(2);
    checks++; if (romAddr !== 5'd26 || score !== 2'd0) begin errors++; $display("FAIL restart2_addr: got %0d %0d want 26 0", romAddr, score); end
    cyc(3);
    checks++; if (currentWord !== rom_word(5'd26) || nextWord !== rom_word(5'd13)) begin errors++; $display("FAIL restart2_words: got %h %h want %h %h", currentWord, nextWord, rom_word(5'd26), rom_word(5'd13)); end
    checks++; if (timeLeft !== 8'd3 || playing !== 1'b1) begin errors++; $display("FAIL restart2_play: got %0d %b want 3 1", timeLeft, playing); end
  endtask

  task automatic test_done_on_final_tick;
    cyc(8);
    checks++; if (timeLeft !== 8'd1) begin errors++; $display("FAIL final_pre: got %0d want 1", timeLeft); end
    wordComplete = 1'b1; cyc(2); wordComplete = 1'b0; cyc(2);
    checks++; if (gameOver !== 1'b0 || playing !== 1'b1 || score !== 2'd1) begin errors++; $display("FAIL final_credit: got %b %b %0d want 0 1 1", gameOver, playing, score); end
    checks++; if (currentWord !== rom_word(5'd13)) begin errors++; $display("FAIL final_cur: got %h want %h", currentWord, rom_word(5'd13)); end
    cyc(1);
    checks++; if (timeLeft !== 8'd3 || nextWord !== rom_word(5'd6)) begin errors++; $display("FAIL final_reload: got %0d %h want 3 %h", timeLeft, nextWord, rom_word(5'd6)); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_s;
    logic [7:0] exp_t;
    for (int i = 2; i <= 5; i++) begin
      wordComplete = 1'b1; cyc(2); wordComplete = 1'b0; cyc(3);
      exp_s = (i >= 3) ? 2'd3 : 2'(i);
      exp_t = !SPEEDUP ? 8'd3 : (i == 4) ? 8'd2 : (i == 5) ? 8'd1 : 8'd3;
      checks++; if (score !== exp_s || timeLeft !== exp_t || checkerReset !== 1'b1) begin errors++; $display("FAIL sat_word%0d: got %0d %0d %b want %0d %0d 1", i, score, timeLeft, checkerReset, exp_s, exp_t); end
    end
  endtask

  task automatic test_reset_play;
    reset = 1'b1; cyc(1);
    checks++; if (romAddr !== 5'd0 || currentWord !== 20'h0 || nextWord !== 20'h0 || score !== 2'd0) begin errors++; $display("FAIL rplay_data: got %0d %h %h %0d want 0 0 0 0", romAddr, currentWord, nextWord, score); end
    checks++; if (timeLeft !== 8'd0 || playing !== 1'b0 || gameOver !== 1'b0 || checkerReset !== 1'b0) begin errors++; $display("FAIL rplay_flags: got %0d %b %b %b want 0 0 0 0", timeLeft, playing, gameOver, checkerReset); end
    reset = 1'b0; cyc(1);
  endtask

  task automatic test_reset_fetch2;
    start = 1'b1; cyc(2); start = 1'b0; cyc(2);
    checks++; if (romAddr !== 5'd1) begin errors++; $display("FAIL reseed_addr: got %0d want 1", romAddr); end
    cyc(1);
    reset = 1'b1; cyc(1);
    checks++; if (romAddr !== 5'd0 || currentWord !== 20'h0 || playing !== 1'b0 || timeLeft !== 8'd0) begin errors++; $display("FAIL rfetch_outs: got %0d %h %b %0d want 0 0 0 0", romAddr, currentWord, playing, timeLeft); end
    reset = 1'b0; cyc(1);
    start = 1'b1; cyc(2); start = 1'b0; cyc(2);
    checks++; if (romAddr !== 5'd1) begin errors++; $display("FAIL rfetch_reseed: got %0d want 1", romAddr); end
    cyc(3);
    checks++; if (currentWord !== 20'h0A4C2 || nextWord !== 20'h12345 || playing !== 1'b1) begin errors++; $display("FAIL rfetch_words: got %h %h %b want 0a4c2 12345 1", currentWord, nextWord, playing); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_advance;
    test_timeout;
    test_simultaneous;
    test_restart;
    test_done_on_final_tick;
    test_saturation;
    test_reset_play;
    test_reset_fetch2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
